// File: rtl/memory_pkg.sv
// memory_pkg
// Shared geometry helpers for the word-wide byte-addressed memory.
// The default constants describe the stock 256-byte / 32-bit configuration;
// the functions let a parameterised instance derive its own geometry.
package memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / 8;
  localparam int OFFSET_BITS    = $clog2(BYTES_PER_WORD);

  // Number of byte lanes in one stored word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside a word.
  function automatic int offset_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Number of words needed to cover the whole byte-address space.
  function automatic int mem_depth(input int addr_width, input int data_width);
    return (2 ** addr_width) / (data_width / 8);
  endfunction

endpackage

// File: rtl/memory.sv
// memory
// Single-port word-wide RAM with a byte address, combinational read and
// synchronous write. Misaligned addresses align down to their word.
// A synchronous active-low reset clears every word and holds data_out at 0.
//
// Ports:
//   clk          - sole clock, all updates on the rising edge
//   rst_n        - synchronous active-low reset
//   addr         - byte address of the accessed word
//   data_in      - write data
//   write_enable - write data_in at the rising edge when high
//   data_out     - combinational read data for addr (0 while in reset)
module memory
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int OFFSET = offset_bits(DATA_WIDTH);
  localparam int DEPTH  = mem_depth(ADDR_WIDTH, DATA_WIDTH);
  // A one-word memory still needs a 1-bit index to declare a vector.
  localparam int IDX_W  = (ADDR_WIDTH > OFFSET) ? (ADDR_WIDTH - OFFSET) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      index;

  // Drop the byte-offset bits so every byte of a word hits the same entry.
  always_comb begin
    word_addr = addr >> OFFSET;
    index     = word_addr[IDX_W-1:0];
  end

  // Storage update: reset wins over a pending write and clears every word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enable) begin
      mem[index] <= data_in;
    end
  end

  // Zero-latency read; masking with rst_n keeps the output clean before the
  // first reset edge has cleared the array.
  always_comb begin
    data_out = '0;
    if (rst_n) begin
      data_out = mem[index];
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb_memory
// Self-checking bench for memory: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// plain word-array model of the memory.
module tb_memory;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;

  int errors = 0;
  int checks = 0;

  // Reference contents: 64 words of 4 bytes covering 256 byte addresses.
  logic [31:0] model_mem [64];

  memory #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out)
  );

  // Free-running 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the memory must hold after each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    end else if (write_enable) begin
      model_mem[addr / 4] = data_in;
    end
  end

  // What data_out must show right now for the current inputs.
  function automatic logic [31:0] modelRead(input logic [7:0] a);
    if (!rst_n) return 32'h0;
    return model_mem[a / 4];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (data_out !== expected) begin
      errors++;
      $display("[TB] FAIL %s: addr=%h data_out=%h expected=%h", name, addr, data_out, expected);
    end
  endtask

  // Drive one set of inputs and let exactly one rising edge consume them;
  // returns 1 ns after that edge.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [7:0] a, input logic [31:0] d);
    rst_n        = r;
    write_enable = w;
    addr         = a;
    data_in      = d;
    @(posedge clk);
    #1;
  endtask

  // Read without writing, away from any edge, and compare to a literal.
  task automatic readAt(input string name, input logic [7:0] a,
                        input logic [31:0] expected);
    @(negedge clk);
    write_enable = 1'b0;
    addr         = a;
    #1;
    checkOutput(name, expected);
  endtask

  // Every cycle, 2 ns after the falling edge, compare against the model.
  always begin
    @(negedge clk);
    #2;
    checkOutput("model_cycle", modelRead(addr));
  end

  initial begin
    rst_n        = 1'b0;
    write_enable = 1'b0;
    addr         = 8'h00;
    data_in      = 32'h0;

    // Output must be zero before any edge while reset is held.
    #1;
    checkOutput("time0_reset", 32'h0);

    // Reset then read.
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    readAt("rst_rd_00", 8'h00, 32'h0);
    readAt("rst_rd_04", 8'h04, 32'h0);
    readAt("rst_rd_08", 8'h08, 32'h0);

    // Write and read back.
    applyStimulus(1'b1, 1'b1, 8'h04, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 8'h08, 32'h12345678);
    readAt("wr_rd_04", 8'h04, 32'hDEADBEEF);
    readAt("wr_rd_08", 8'h08, 32'h12345678);
    readAt("wr_rd_00", 8'h00, 32'h0);

    // Misaligned addresses align down to the word.
    applyStimulus(1'b1, 1'b1, 8'h10, 32'hCAFEF00D);
    readAt("align_11", 8'h11, 32'hCAFEF00D);
    readAt("align_12", 8'h12, 32'hCAFEF00D);
    readAt("align_13", 8'h13, 32'hCAFEF00D);
    readAt("align_14", 8'h14, 32'h0);
    applyStimulus(1'b1, 1'b1, 8'h07, 32'h0BADCAFE);
    readAt("align_wr_04", 8'h04, 32'h0BADCAFE);

    // Top of the address range.
    applyStimulus(1'b1, 1'b1, 8'hFC, 32'hA5A5A5A5);
    readAt("top_fc", 8'hFC, 32'hA5A5A5A5);
    readAt("top_ff", 8'hFF, 32'hA5A5A5A5);
    readAt("top_00", 8'h00, 32'h0);

    // Read-during-write on the same address: old before, new after the edge.
    @(negedge clk);
    rst_n        = 1'b1;
    write_enable = 1'b1;
    addr         = 8'h08;
    data_in      = 32'h55AA55AA;
    #1;
    checkOutput("rdw_before", 32'h12345678);
    @(posedge clk);
    #1;
    checkOutput("rdw_after", 32'h55AA55AA);
    write_enable = 1'b0;

    // Reset mid-operation drops a concurrent write.
    applyStimulus(1'b1, 1'b1, 8'h20, 32'h11111111);
    readAt("mid_pre", 8'h20, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 8'h20, 32'h22222222);
    checkOutput("mid_in_reset", 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0);
    readAt("mid_post_20", 8'h20, 32'h0);
    readAt("mid_post_04", 8'h04, 32'h0);

    // Write-enable low leaves contents alone.
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h30, 32'hFFFFFFFF);
    readAt("we_low_30", 8'h30, 32'h0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 99) >= 3),
                    ($urandom_range(0, 1) == 1),
                    8'($urandom_range(0, 255)),
                    $urandom());
    end
    write_enable = 1'b0;
    rst_n        = 1'b1;

    // Sweep every word once more so stale or X entries surface.
    for (int a = 0; a < 256; a += 4) begin
      @(negedge clk);
      addr = 8'(a + $urandom_range(0, 3));
      #1;
      checkOutput("sweep", modelRead(addr));
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
Single-port, word-wide random-access memory with a byte address, asynchronous (combinational) read and synchronous write. It serves as the generic data/instruction store for the core and for bench-level integration. A synchronous active-low reset clears every stored word to zero.

Parameters:
- ADDR_WIDTH, 8: byte-address width; the address space is 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8 and a power of two, with DATA_WIDTH/8 <= 2^ADDR_WIDTH.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- addr  input  ADDR_WIDTH  byte address of the word accessed.
- data_in  input  DATA_WIDTH  write data.
- write_enable  input  1  when high at a rising edge, data_in is written.
- data_out  output  DATA_WIDTH  read data for addr (combinational).

Behaviour:
- One clock (clk), synchronous active-low reset (rst_n); no other clocks or async paths.
- Storage:
  - DEPTH = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
  - The word index is addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
  - The low log2(DATA_WIDTH/8) address bits are ignored, so misaligned addresses align down (e.g. 0x05 accesses word at 0x04).
- Reset:
  - At a rising edge with rst_n=0, every word is set to 0.
  - Reset has priority over write_enable; a write requested during reset is dropped.
  - While rst_n=0, data_out is forced to 0, independent of storage contents; this covers time 0 before the first edge.
- Write:
  - At a rising edge with rst_n=1 and write_enable=1, the word at the index is replaced by data_in.
  - Full-word write only; no byte enables.
- Read:
  - data_out = mem[index] combinationally, with zero clock latency.
  - It follows addr changes within the same cycle and settles within a delta cycle.
- Read-during-write, same address:
  - Before the edge, data_out shows the old value.
  - After the edge, it shows data_in (write-first visible the same cycle post-edge).
- Addresses outside the range cannot occur; the full ADDR_WIDTH range maps onto DEPTH words with no wrap logic needed.
- write_enable=0 leaves contents unchanged regardless of data_in.
- No X on data_out after the first reset edge for any addr.

Decomposition:
- Package memory_pkg:
  - BYTES_PER_WORD = DATA_WIDTH/8.
  - OFFSET_BITS = $clog2(BYTES_PER_WORD).
  - A DEPTH helper function.
- No sub-module; a single flat module with one storage array, one clocked process and one combinational read.

Test Plan:
- Reset then read: hold rst_n=0 for 5 cycles, release, read 0x00, 0x04, 0x08 -> data_out=0x00000000 each, 1 ns after addr changes.
- Write/readback: write 0xDEADBEEF @0x04 and 0x12345678 @0x08 -> read 0x04=0xDEADBEEF, 0x08=0x12345678, 0x00=0x00000000.
- Alignment: after writing 0xCAFEF00D @0x10, read 0x11, 0x12, 0x13 -> all 0xCAFEF00D; read 0x14 -> 0.
- Top of range: write 0xA5A5A5A5 @0xFC -> read 0xFC=0xA5A5A5A5, 0x00 unchanged.
- Reset mid-operation: write 0x11111111 @0x20, assert rst_n=0 with write_enable=1 and data_in=0x22222222 @0x20 for one edge, release -> read 0x20=0x00000000; data_out=0 while rst_n=0.
- Write-enable low: drive data_in=0xFFFFFFFF @0x30 with write_enable=0 for 3 edges -> read 0x30=0x00000000.
